// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard controller.
// Opcodes match instruction bits [15:12] of the 16-bit RISC core.
package pipe_hazard_ctrl_pkg;

  localparam logic [3:0] OP_LW = 4'b0100;
  localparam logic [3:0] OP_LM = 4'b0110;
  localparam logic [3:0] OP_SM = 4'b0111;

  localparam int LIST_W = 8;

  typedef enum logic {
    RUN = 1'b0,
    SEQ = 1'b1
  } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the IF/ID, ID/EX pipeline registers and the hazard controller.
// No handshake: every field is sampled combinationally each cycle.
interface pipe_hazard_ctrl_if;
  import pipe_hazard_ctrl_pkg::*;

  logic              ID_VALID;
  logic [3:0]        ID_OPCODE;
  logic [2:0]        ID_RA;
  logic [2:0]        ID_RB;
  logic [LIST_W-1:0] ID_REGLIST;
  logic              EX_VALID;
  logic              EX_IS_LOAD;
  logic [2:0]        EX_RD;
  logic              BR_TAKEN;

  logic              PC_WR_EN;
  logic              IF_ID_EN;
  logic              IF_ID_CLR;
  logic              ID_EX_CLR;
  logic              UOP_VALID;
  logic [2:0]        UOP_REG;
  logic [2:0]        UOP_OFFSET;
  logic              UOP_LAST;
  logic              BUSY;

  modport master (
    output ID_VALID, ID_OPCODE, ID_RA, ID_RB, ID_REGLIST,
    output EX_VALID, EX_IS_LOAD, EX_RD, BR_TAKEN,
    input  PC_WR_EN, IF_ID_EN, IF_ID_CLR, ID_EX_CLR,
    input  UOP_VALID, UOP_REG, UOP_OFFSET, UOP_LAST, BUSY
  );

  modport slave (
    input  ID_VALID, ID_OPCODE, ID_RA, ID_RB, ID_REGLIST,
    input  EX_VALID, EX_IS_LOAD, EX_RD, BR_TAKEN,
    output PC_WR_EN, IF_ID_EN, IF_ID_CLR, ID_EX_CLR,
    output UOP_VALID, UOP_REG, UOP_OFFSET, UOP_LAST, BUSY
  );

endinterface

// File: rtl/pipe_hazard_ctrl_lmsm_pri_enc.sv
// Priority encoder over an LM/SM register list; bit 7 is R0, so scanning
// from the MSB yields the lowest register index first.
module lmsm_pri_enc
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [LIST_W-1:0] mask,
  output logic [2:0]        idx,
  output logic [LIST_W-1:0] rest,
  output logic              last,
  output logic              empty
);

  logic found;

  always_comb begin
    idx   = '0;
    rest  = mask;
    found = 1'b0;
    for (int i = LIST_W - 1; i >= 0; i--) begin
      if (!found && mask[i]) begin
        found   = 1'b1;
        idx     = 3'(LIST_W - 1 - i);
        rest[i] = 1'b0;
      end
    end
  end

  assign last  = $onehot(mask);
  assign empty = (mask == '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control: EX-resolved flushes, one-cycle load-use stalls and
// LM/SM expansion into one micro-op per listed register.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int LMSM_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  pipe_hazard_ctrl_if.slave bus
);

  state_t            state_q, state_d;
  logic [LIST_W-1:0] mask_q, mask_d;
  logic [2:0]        cnt_q, cnt_d;

  logic [LIST_W-1:0] enc_in, enc_rest;
  logic [2:0]        enc_idx;
  logic              enc_last, enc_empty;
  logic              load_use, is_lmsm;

  // In SEQ the encoder walks the pending mask; in RUN it looks at the fresh list.
  assign enc_in = (state_q == SEQ) ? mask_q : bus.ID_REGLIST;

  lmsm_pri_enc u_pri_enc (
    .mask  (enc_in),
    .idx   (enc_idx),
    .rest  (enc_rest),
    .last  (enc_last),
    .empty (enc_empty)
  );

  assign load_use = bus.EX_VALID && bus.EX_IS_LOAD && bus.ID_VALID &&
                    ((bus.EX_RD == bus.ID_RA) || (bus.EX_RD == bus.ID_RB));
  assign is_lmsm  = (LMSM_EN != 0) && bus.ID_VALID &&
                    ((bus.ID_OPCODE == OP_LM) || (bus.ID_OPCODE == OP_SM));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      mask_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    mask_d         = mask_q;
    cnt_d          = cnt_q;
    bus.PC_WR_EN   = 1'b1;
    bus.IF_ID_EN   = 1'b1;
    bus.IF_ID_CLR  = 1'b0;
    bus.ID_EX_CLR  = 1'b0;
    bus.UOP_VALID  = 1'b0;
    bus.UOP_REG    = '0;
    bus.UOP_OFFSET = '0;
    bus.UOP_LAST   = 1'b0;

    if (!rst_n) begin
      bus.PC_WR_EN  = 1'b0;
      bus.IF_ID_EN  = 1'b0;
      bus.IF_ID_CLR = 1'b1;
      bus.ID_EX_CLR = 1'b1;
      state_d       = RUN;
      mask_d        = '0;
      cnt_d         = '0;
    end else if (bus.BR_TAKEN) begin
      bus.IF_ID_CLR = 1'b1;
      bus.ID_EX_CLR = 1'b1;
      state_d       = RUN;
      mask_d        = '0;
      cnt_d         = '0;
    end else if (state_q == SEQ) begin
      bus.UOP_VALID  = !enc_empty;
      bus.UOP_REG    = enc_idx;
      bus.UOP_OFFSET = cnt_q;
      mask_d         = enc_rest;
      cnt_d          = cnt_q + 3'd1;
      // Fetch resumes in the same cycle the final register issues.
      if (enc_last || enc_empty) begin
        bus.UOP_LAST = !enc_empty;
        state_d      = RUN;
        cnt_d        = '0;
      end else begin
        bus.PC_WR_EN = 1'b0;
        bus.IF_ID_EN = 1'b0;
      end
    end else if (load_use) begin
      bus.PC_WR_EN  = 1'b0;
      bus.IF_ID_EN  = 1'b0;
      bus.ID_EX_CLR = 1'b1;
    end else if (is_lmsm && !enc_empty) begin
      bus.UOP_VALID = 1'b1;
      bus.UOP_REG   = enc_idx;
      if (enc_last) begin
        bus.UOP_LAST = 1'b1;
      end else begin
        bus.PC_WR_EN = 1'b0;
        bus.IF_ID_EN = 1'b0;
        mask_d       = enc_rest;
        cnt_d        = 3'd1;
        state_d      = SEQ;
      end
    end
  end

  assign bus.BUSY = (state_q == SEQ);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: vector table, hand-written multi-cycle sequences,
// then random traffic against a queue-based reference model.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  pipe_hazard_ctrl_if bus ();
  pipe_hazard_ctrl_if bus2 ();

  pipe_hazard_ctrl #(.LMSM_EN(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  pipe_hazard_ctrl #(.LMSM_EN(0)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

  assign bus2.ID_VALID   = bus.ID_VALID;
  assign bus2.ID_OPCODE  = bus.ID_OPCODE;
  assign bus2.ID_RA      = bus.ID_RA;
  assign bus2.ID_RB      = bus.ID_RB;
  assign bus2.ID_REGLIST = bus.ID_REGLIST;
  assign bus2.EX_VALID   = bus.EX_VALID;
  assign bus2.EX_IS_LOAD = bus.EX_IS_LOAD;
  assign bus2.EX_RD      = bus.EX_RD;
  assign bus2.BR_TAKEN   = bus.BR_TAKEN;

  // Output vector: {pc, ifen, ifclr, idexclr, uv, reg[2:0], off[2:0], last, busy}
  logic [12:0] got1, got2;
  assign got1 = {bus.PC_WR_EN, bus.IF_ID_EN, bus.IF_ID_CLR, bus.ID_EX_CLR, bus.UOP_VALID,
                 bus.UOP_REG, bus.UOP_OFFSET, bus.UOP_LAST, bus.BUSY};
  assign got2 = {bus2.PC_WR_EN, bus2.IF_ID_EN, bus2.IF_ID_CLR, bus2.ID_EX_CLR, bus2.UOP_VALID,
                 bus2.UOP_REG, bus2.UOP_OFFSET, bus2.UOP_LAST, bus2.BUSY};

  function automatic logic [12:0] e(input logic pc, input logic ifen, input logic ifclr,
                                    input logic idclr, input logic uv, input logic [2:0] r,
                                    input logic [2:0] o, input logic last, input logic busy);
    return {pc, ifen, ifclr, idclr, uv, r, o, last, busy};
  endfunction

  localparam logic [12:0] NORM  = 13'b1100_0000_0000_0;
  localparam logic [12:0] STALL = 13'b0001_0000_0000_0;
  localparam logic [12:0] FLUSH = 13'b1111_0000_0000_0;
  localparam logic [12:0] RSTV  = 13'b0011_0000_0000_0;
  localparam logic [3:0]  OP_ADD = 4'b0000;

  typedef struct {
    logic        idv;
    logic [3:0]  op;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [7:0]  rl;
    logic        exv;
    logic        exl;
    logic [2:0]  exrd;
    logic        br;
    logic [12:0] exp;
  } vec_t;

  vec_t tbl[12];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [12:0] got, input logic [12:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic drive(input logic idv, input logic [3:0] op, input logic [2:0] ra,
                       input logic [2:0] rb, input logic [7:0] rl, input logic exv,
                       input logic exl, input logic [2:0] exrd, input logic br);
    bus.ID_VALID   = idv;
    bus.ID_OPCODE  = op;
    bus.ID_RA      = ra;
    bus.ID_RB      = rb;
    bus.ID_REGLIST = rl;
    bus.EX_VALID   = exv;
    bus.EX_IS_LOAD = exl;
    bus.EX_RD      = exrd;
    bus.BR_TAKEN   = br;
  endtask

  function automatic vec_t mk(input logic idv, input logic [3:0] op, input logic [2:0] ra,
                              input logic [2:0] rb, input logic [7:0] rl, input logic exv,
                              input logic exl, input logic [2:0] exrd, input logic br,
                              input logic [12:0] exp);
    vec_t v;
    v.idv = idv; v.op = op; v.ra = ra; v.rb = rb; v.rl = rl;
    v.exv = exv; v.exl = exl; v.exrd = exrd; v.br = br; v.exp = exp;
    return v;
  endfunction

  // Reference model state: registers still owed by the current LM/SM, and next ordinal.
  int pend_q[$];
  int ord;

  logic       r_idv, r_exv, r_exl, r_br;
  logic [3:0] r_op;
  logic [2:0] r_ra, r_rb, r_exrd;
  logic [7:0] r_rl;

  initial begin
    int          lst[$];
    int          r;
    bit          hz, lm, l;
    int          sel;
    logic [12:0] x1, x2;

    tbl[0]  = mk(1, OP_ADD, 1, 2, 8'h00, 1, 1, 4, 0, NORM);
    tbl[1]  = mk(1, OP_ADD, 1, 3, 8'h00, 1, 1, 3, 0, STALL);
    tbl[2]  = mk(1, OP_ADD, 5, 0, 8'h00, 1, 1, 5, 0, STALL);
    tbl[3]  = mk(1, OP_ADD, 1, 3, 8'h00, 1, 0, 3, 0, NORM);
    tbl[4]  = mk(0, OP_ADD, 1, 3, 8'h00, 1, 1, 3, 0, NORM);
    tbl[5]  = mk(1, OP_LM,  3, 0, 8'hA1, 1, 1, 3, 1, FLUSH);
    tbl[6]  = mk(1, OP_SM,  1, 0, 8'h04, 0, 0, 0, 0, e(1, 1, 0, 0, 1, 5, 0, 1, 0));
    tbl[7]  = mk(1, OP_LM,  1, 0, 8'h00, 0, 0, 0, 0, NORM);
    tbl[8]  = mk(1, OP_LM,  1, 0, 8'hA1, 0, 0, 0, 0, e(0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl[9]  = mk(1, OP_LM,  6, 0, 8'hA1, 1, 1, 6, 0, STALL);
    tbl[10] = mk(0, OP_LM,  1, 0, 8'hA1, 0, 0, 0, 0, NORM);
    tbl[11] = mk(1, OP_LW,  2, 1, 8'h00, 1, 0, 1, 0, NORM);

    // Reset values
    rst_n = 1'b0;
    drive(1, OP_LM, 1, 0, 8'hA1, 0, 0, 0, 0);
    #2;
    check("reset_dut", got1, RSTV);
    check("reset_dut2", got2, RSTV);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, OP_ADD, 0, 0, 8'h00, 0, 0, 0, 0);
    @(negedge clk);

    // Single-cycle vectors, each from RUN; a flush cycle afterwards restores RUN.
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].idv, tbl[i].op, tbl[i].ra, tbl[i].rb, tbl[i].rl,
            tbl[i].exv, tbl[i].exl, tbl[i].exrd, tbl[i].br);
      #2;
      check($sformatf("vec%0d", i), got1, tbl[i].exp);
      @(negedge clk);
      drive(0, OP_ADD, 0, 0, 8'h00, 0, 0, 0, 1);
      @(negedge clk);
    end

    // LM R0,R2,R7 over three cycles
    drive(1, OP_LM, 1, 0, 8'hA1, 0, 0, 0, 0);
    #2;
    check("lm_c0", got1, e(0, 0, 0, 0, 1, 0, 0, 0, 0));
    check("lm_c0_noen", got2, NORM);
    @(negedge clk); #2;
    check("lm_c1", got1, e(0, 0, 0, 0, 1, 2, 1, 0, 1));
    check("lm_c1_noen", got2, NORM);
    @(negedge clk); #2;
    check("lm_c2", got1, e(1, 1, 0, 0, 1, 7, 2, 1, 1));
    @(negedge clk);
    drive(1, OP_ADD, 1, 2, 8'h00, 0, 0, 0, 0);
    #2;
    check("lm_done", got1, NORM);
    @(negedge clk);

    // Load-use stall lasts one cycle
    drive(1, OP_ADD, 1, 3, 8'h00, 1, 1, 3, 0);
    #2;
    check("lu_stall", got1, STALL);
    @(negedge clk);
    drive(1, OP_ADD, 1, 3, 8'h00, 0, 0, 0, 0);
    #2;
    check("lu_release", got1, NORM);
    @(negedge clk);

    // Reset asserted mid-SEQ with 8'b0011_0000 pending
    drive(1, OP_LM, 1, 0, 8'hB0, 0, 0, 0, 0);
    #2;
    check("rs_c0", got1, e(0, 0, 0, 0, 1, 0, 0, 0, 0));
    @(negedge clk); #2;
    check("rs_seq", got1, e(0, 0, 0, 0, 1, 2, 1, 0, 1));
    #1 rst_n = 1'b0;
    #1;
    check("rs_in_reset", got1, RSTV);
    @(negedge clk);
    drive(1, OP_ADD, 1, 2, 8'h00, 0, 0, 0, 0);
    #1 rst_n = 1'b1;
    #1;
    check("rs_release", got1, NORM);
    @(negedge clk); #2;
    check("rs_after_edge", got1, NORM);
    @(negedge clk);

    // Branch taken while sequencing aborts the LM
    drive(1, OP_LM, 1, 0, 8'hF0, 0, 0, 0, 0);
    @(negedge clk);
    drive(1, OP_LM, 1, 0, 8'hF0, 1, 1, 1, 1);
    #2;
    check("br_in_seq", got1, e(1, 1, 1, 1, 0, 0, 0, 0, 1));
    @(negedge clk);
    drive(1, OP_ADD, 1, 2, 8'h00, 0, 0, 0, 0);
    #2;
    check("br_after", got1, NORM);
    @(negedge clk);

    // Random traffic against the reference model
    pend_q.delete();
    ord = 0;
    for (int n = 0; n < 400; n++) begin
      sel    = $urandom_range(0, 7);
      r_op   = (sel < 2) ? OP_LM : (sel == 2) ? OP_SM : (sel == 3) ? OP_LW : 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0:       r_rl = 8'h00;
        1:       r_rl = 8'(1 << $urandom_range(0, 7));
        default: r_rl = 8'($urandom_range(0, 255));
      endcase
      r_idv  = ($urandom_range(0, 7) != 0);
      r_ra   = 3'($urandom_range(0, 7));
      r_rb   = 3'($urandom_range(0, 7));
      r_exv  = 1'($urandom_range(0, 1));
      r_exl  = 1'($urandom_range(0, 1));
      r_exrd = 3'($urandom_range(0, 7));
      r_br   = ($urandom_range(0, 9) == 0);
      drive(r_idv, r_op, r_ra, r_rb, r_rl, r_exv, r_exl, r_exrd, r_br);

      hz = r_exv && r_exl && r_idv && (r_exrd == r_ra || r_exrd == r_rb);
      lm = r_idv && (r_op == OP_LM || r_op == OP_SM);
      lst.delete();
      for (int k = 0; k < 8; k++) if (r_rl[7-k]) lst.push_back(k);

      if (r_br) begin
        x1 = e(1, 1, 1, 1, 0, 0, 0, 0, pend_q.size() > 0);
        pend_q.delete();
        ord = 0;
      end else if (pend_q.size() > 0) begin
        r = pend_q.pop_front();
        l = (pend_q.size() == 0);
        x1 = e(l, l, 0, 0, 1, 3'(r), 3'(ord), l, 1);
        ord++;
      end else if (hz) begin
        x1 = STALL;
      end else if (lm && lst.size() > 0) begin
        l = (lst.size() == 1);
        x1 = e(l, l, 0, 0, 1, 3'(lst[0]), 0, l, 0);
        if (!l) begin
          pend_q = lst;
          void'(pend_q.pop_front());
          ord = 1;
        end
      end else begin
        x1 = NORM;
      end
      x2 = r_br ? FLUSH : hz ? STALL : NORM;

      #2;
      check($sformatf("rand%0d", n), got1, x1);
      check($sformatf("rand%0d_noen", n), got2, x2);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
